// File: rtl/seq_checker.sv
// seq_checker: locks onto a 4-symbol gray-less counting stream and flags step/dwell faults
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in0, in1            incoming symbol {in0,in1} from the upstream sequencer
//   sym, all3           registered symbol and registered sym==11
//   locked              high while in LOCK
//   wrap, err           one-cycle pulses for a locked 11->00 wrap and for a locked fault
//   err_code            cause of the last fault (bit0 bad step, bit1 bad dwell/stall)
//   cycle_cnt, err_cnt  saturating counts of wrap and err pulses
module seq_checker #(
    parameter int HOLD  = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    input  logic             in1,
    output logic [1:0]       sym,
    output logic             all3,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;
    state_t     state, state_nx;
    logic [1:0] s;
    logic [7:0] dwell_cnt;
    logic       change, legal, dwell_ok, fault, wrap_nx;
    logic [1:0] code_nx;
    assign s = {in0, in1};
    always_comb begin
        change   = s != sym;
        legal    = s == sym + 2'd1;
        dwell_ok = dwell_cnt == 8'(HOLD);
        state_nx = state;
        fault    = 1'b0;
        code_nx  = err_code;
        wrap_nx  = 1'b0;
        case (state)
            HUNT: state_nx = change && legal ? SYNC : HUNT;
            SYNC: state_nx = !change ? SYNC : legal && dwell_ok ? LOCK : HUNT;
            LOCK: begin
                if (change && legal && dwell_ok) begin
                    wrap_nx = sym == 2'b11;
                end else if (change || dwell_ok) begin
                    // a change with a bad step/dwell, or a stall once the hold time has elapsed
                    state_nx = HUNT;
                    fault    = 1'b1;
                    code_nx  = change ? {!dwell_ok, !legal} : 2'b10;
                end
            end
            default: state_nx = HUNT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            sym       <= 2'b00;
            dwell_cnt <= 8'd0;
            all3      <= 1'b0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            cycle_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            sym       <= s;
            all3      <= s == 2'b11;
            dwell_cnt <= change ? 8'd1 : &dwell_cnt ? dwell_cnt : dwell_cnt + 8'd1;
            locked    <= state_nx == LOCK;
            wrap      <= wrap_nx;
            err       <= fault;
            if (fault) err_code <= code_nx;
            if (wrap_nx && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (fault && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed stream with a wrap/err event scoreboard over two counter widths
module tb_seq_checker;
    logic       clk, rst_n, in0, in1;
    logic [1:0] sym, sym2, err_code, err_code2;
    logic       all3, all3_2, locked, locked2, wrap, wrap2, err, err2;
    logic [7:0] cycle_cnt, err_cnt;
    logic [1:0] cycle_cnt2, err_cnt2;

    seq_checker #(.HOLD(6), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sym(sym), .all3(all3),
        .locked(locked), .wrap(wrap), .err(err), .err_code(err_code),
        .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
    );
    seq_checker #(.HOLD(6), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sym(sym2), .all3(all3_2),
        .locked(locked2), .wrap(wrap2), .err(err2), .err_code(err_code2),
        .cycle_cnt(cycle_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        int         cyc;
        int         errs;
    } ev_t;
    ev_t        q[$];
    int         checks = 0, errors = 0;
    int         exp_cyc = 0, exp_err = 0;
    logic [1:0] exp_code = 2'b00;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat2(input int v);
        return v > 3 ? 3 : v;
    endfunction

    task automatic hold(input logic [1:0] v, input int n);
        {in0, in1} = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wrap();
        exp_cyc++;
        q.push_back('{1'b0, exp_code, exp_cyc, exp_err});
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_err++;
        exp_code = code;
        q.push_back('{1'b1, code, exp_cyc, exp_err});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sym"}, {sym, sym2}, 0);
        chk({tag, "_all3"}, {all3, all3_2}, 0);
        chk({tag, "_locked"}, {locked, locked2}, 0);
        chk({tag, "_pulses"}, {wrap, err, wrap2, err2}, 0);
        chk({tag, "_err_code"}, {err_code, err_code2}, 0);
        chk({tag, "_cycle_cnt"}, {cycle_cnt, cycle_cnt2}, 0);
        chk({tag, "_err_cnt"}, {err_cnt, err_cnt2}, 0);
    endtask

    task automatic lap();
        hold(2'b00, 5);
        hold(2'b01, 6);
        hold(2'b10, 6);
        hold(2'b11, 6);
        push_wrap();
        hold(2'b00, 1);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (wrap || err || wrap2 || err2)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {wrap, err, wrap2, err2}, 0);
            end else begin
                e = q.pop_front();
                chk("ev_err", {err, err2}, {2{e.is_err}});
                chk("ev_wrap", {wrap, wrap2}, {2{!e.is_err}});
                chk("ev_err_code", err_code, e.code);
                chk("ev_err_code2", err_code2, e.code);
                chk("ev_locked", {locked, locked2}, {2{!e.is_err}});
                chk("ev_cycle_cnt", cycle_cnt, e.cyc);
                chk("ev_err_cnt", err_cnt, e.errs);
                chk("ev_cycle_cnt2", cycle_cnt2, sat2(e.cyc));
                chk("ev_err_cnt2", err_cnt2, sat2(e.errs));
            end
        end
    end

    initial begin
        rst_n = 0;
        {in0, in1} = 2'b00;
        #3 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        hold(2'b00, 6);
        hold(2'b01, 6);
        chk("sync_not_locked", locked, 0);
        hold(2'b10, 1);
        chk("first_lock", {locked, locked2}, 2'b11);
        hold(2'b10, 5);
        hold(2'b11, 6);
        chk("all3_sym", {all3, sym}, 3'b111);
        push_wrap();
        hold(2'b00, 1);
        chk("wrap_visible", {wrap, cycle_cnt}, {1'b1, 8'd1});
        repeat (4) lap();
        // short dwell on 01 -> dwell fault, then relock through SYNC
        hold(2'b00, 5);
        hold(2'b01, 5);
        push_err(2'b10);
        hold(2'b10, 1);
        chk("short_dwell_unlock", {locked, err_code}, {1'b0, 2'b10});
        hold(2'b10, 5);
        hold(2'b11, 6);
        hold(2'b00, 1);
        chk("relock_code_kept", {locked, err_code}, {1'b1, 2'b10});
        // illegal step 01->11 with correct dwell
        hold(2'b00, 5);
        hold(2'b01, 6);
        push_err(2'b01);
        hold(2'b11, 1);
        chk("bad_step_unlock", {locked, err_code}, {1'b0, 2'b01});
        hold(2'b11, 5);
        hold(2'b00, 6);
        hold(2'b01, 1);
        chk("relock2", locked, 1);
        // stall on 10: fault on its 7th edge, then silence while hunting
        hold(2'b01, 5);
        hold(2'b10, 6);
        push_err(2'b10);
        hold(2'b10, 1);
        chk("stall_unlock", {locked, err_code}, {1'b0, 2'b10});
        hold(2'b10, 20);
        chk("hunt_quiet", locked, 0);
        // illegal step with short dwell -> both fault bits
        hold(2'b11, 6);
        hold(2'b00, 1);
        chk("relock3", locked, 1);
        hold(2'b00, 3);
        push_err(2'b11);
        hold(2'b10, 1);
        chk("both_faults", {locked, err_code, err_cnt2}, {1'b0, 2'b11, 2'b11});
        hold(2'b10, 5);
        hold(2'b11, 6);
        hold(2'b00, 1);
        chk("relock4", locked, 1);
        hold(2'b00, 3);
        // asynchronous reset between edges while locked
        #2 rst_n = 0;
        #1 check_zero("mid_reset");
        exp_cyc = 0;
        exp_err = 0;
        exp_code = 2'b00;
        @(posedge clk);
        #1 rst_n = 1;
        hold(2'b00, 6);
        hold(2'b01, 6);
        chk("post_reset_sync", locked, 0);
        hold(2'b10, 1);
        chk("post_reset_lock", locked, 1);
        hold(2'b10, 5);
        hold(2'b11, 6);
        push_wrap();
        hold(2'b00, 3);
        chk("post_reset_cycle_cnt", {cycle_cnt, cycle_cnt2}, {8'd1, 2'd1});
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter HOLD, default 6, meaning the required number of clock edges each symbol is held (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of cycle_cnt and err_cnt.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in0  input  1  symbol MSB from the upstream 4-state sequencer.
REQ-006 SHALL have port in1  input  1  symbol LSB from the upstream 4-state sequencer.
REQ-007 SHALL have port sym  output  2  registered symbol {in0,in1}.
REQ-008 SHALL have port all3  output  1  registered sym==2'b11.
REQ-009 SHALL have port locked  output  1  high while the FSM is in LOCK.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse per completed 11->00 wrap while locked.
REQ-011 SHALL have port err  output  1  one-cycle pulse per detected fault while locked.
REQ-012 SHALL have port err_code  output  2  fault cause, held until the next fault: 01 bad step, 10 bad dwell/stall, 11 both.
REQ-013 SHALL have port cycle_cnt  output  CNT_W  saturating count of wrap pulses.
REQ-014 SHALL have port err_cnt  output  CNT_W  saturating count of err pulses.

Function
REQ-015 SHALL sample s={in0,in1} every edge into sym; change = (s != sym) evaluated before the update.
REQ-016 SHALL keep an 8-bit dwell_cnt: set to 1 on an edge with change, incremented (saturating at 255) on an edge without change; measured dwell at a change edge = dwell_cnt before update.
REQ-017 SHALL define a legal step as s == sym+1 mod 4 (00->01->10->11->00).
REQ-018 SHALL implement FSM states HUNT, SYNC, LOCK; reset state HUNT.
REQ-019 HUNT: on change with legal step -> SYNC; on illegal change stay HUNT; no err, no dwell check.
REQ-020 SYNC: on change with legal step and dwell==HOLD -> LOCK; any other change -> HUNT; no err.
REQ-021 LOCK: on change with legal step and dwell==HOLD stay LOCK; otherwise -> HUNT with err fault; err_code bit0 = illegal step, bit1 = dwell!=HOLD.
REQ-022 LOCK: on an edge with no change while dwell_cnt==HOLD (stall) -> HUNT with err fault, err_code=10.
REQ-023 SHALL drive err, wrap, locked, sym, all3 from registers: visible in the cycle after the causing edge.
REQ-024 SHALL pulse wrap and increment cycle_cnt on a LOCK-staying change from 11 to 00; wrap and err SHALL never assert together.
REQ-025 SHALL increment err_cnt on each err pulse; both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 SHALL not alter err_code on non-fault edges.

Reset
REQ-027 SHALL, while rst_n is low, force immediately (no clock): state HUNT, sym=00, dwell_cnt=0, all3=0, locked=0, wrap=0, err=0, err_code=00, cycle_cnt=0, err_cnt=0.
REQ-028 SHALL resume sampling on the first rising edge after rst_n deasserts; reset mid-LOCK discards all progress.

Verification
REQ-029 Reset, then 00x6,01x6,10x6,11x6 repeating (HOLD=6) -> locked=1 after the 01->10 edge; wrap=1 one cycle after the 11->00 edge, cycle_cnt=1; err never asserts.
REQ-030 Locked, then 01 held 5 edges before 10 -> err=1 one cycle, err_code=10, locked=0, err_cnt=1; relock after two further legal 6-edge steps.
REQ-031 Locked, 01 held 6 edges then 11 -> err=1, err_code=01, locked=0.
REQ-032 Locked, 10 held indefinitely -> err=1 with err_code=10 on the 7th edge of 10; no further err while in HUNT.
REQ-033 CNT_W=2, ideal stream for 5 wraps -> cycle_cnt 1,2,3,3,3; wrap still pulses each time.
REQ-034 Locked with cycle_cnt=2, pull rst_n low between edges -> all outputs 0 before the next clock; after release, same ideal stream relocks with cycle_cnt counting from 0.
